// File: rtl/weight_bin_counter.sv
// Scale item sorter: classifies each weight into a group and counts one item
// per settled placement, with saturating per-group and total counters.
module weight_bin_counter #(
    parameter int unsigned W      = 12,
    parameter int unsigned NGRP   = 6,
    parameter int unsigned CW     = 8,
    parameter int unsigned STABLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      weight,
    input  logic              clr,
    input  logic              thr_we,
    input  logic [3:0]        thr_idx,
    input  logic [W-1:0]      thr_data,
    output logic [3:0]        cur_grp,
    output logic [NGRP*CW-1:0] counts,
    output logic [NGRP-1:0]   sat,
    output logic              cnt_pulse,
    output logic [3:0]        cnt_grp,
    output logic [15:0]       total
);

    localparam logic [1:0]    S_EMPTY  = 2'd0;
    localparam logic [1:0]    S_SETTLE = 2'd1;
    localparam logic [1:0]    S_HELD   = 2'd2;
    localparam int unsigned   NTHR     = NGRP - 1;
    localparam logic [3:0]    STABLE_C = 4'(STABLE);
    localparam logic [3:0]    THR_LAST = 4'(NGRP - 2);
    localparam logic [3:0]    GRP_TOP  = 4'(NGRP);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [W-1:0]  r_thr [NTHR];
    logic [CW-1:0] r_cnt [NGRP];
    logic [NGRP-1:0] r_sat;
    logic [15:0]   r_total;
    logic          r_cnt_pulse;
    logic [3:0]    r_cnt_grp;

    logic [1:0]    r_state, w_state_nx;
    logic [3:0]    r_cand,  w_cand_nx;
    logic [3:0]    r_stab,  w_stab_nx;
    logic [3:0]    w_grp;
    logic          w_take;

    // Smallest-index threshold wins: scan downward so lower indices overwrite.
    always_comb begin
        w_grp = GRP_TOP;
        for (int i = int'(NTHR) - 1; i >= 0; i--) begin
            if (weight < r_thr[i]) w_grp = 4'(i + 1);
        end
        if (weight == '0) w_grp = 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NTHR); i++) r_thr[i] <= W'(250 * (i + 1) + 1);
        end else if (thr_we && (thr_idx <= THR_LAST)) begin
            r_thr[thr_idx[$clog2(NTHR+1)-1:0]] <= thr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_cand  <= 4'd0;
            r_stab  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_stab  <= w_stab_nx;
        end
    end

    // Placement debounce: count once when a group has held STABLE cycles.
    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_stab_nx  = r_stab;
        w_take     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_grp != 4'd0) begin
                    w_cand_nx = w_grp;
                    w_stab_nx = 4'd1;
                    if (STABLE_C == 4'd1) begin
                        w_take     = 1'b1;
                        w_state_nx = S_HELD;
                    end else begin
                        w_state_nx = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (w_grp == 4'd0) begin
                    w_state_nx = S_EMPTY;
                    w_stab_nx  = 4'd0;
                end else if (w_grp != r_cand) begin
                    w_cand_nx = w_grp;
                    w_stab_nx = 4'd1;
                end else begin
                    w_stab_nx = 4'(r_stab + 4'd1);
                    if (4'(r_stab + 4'd1) == STABLE_C) begin
                        w_take     = 1'b1;
                        w_state_nx = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (w_grp == 4'd0) begin
                    w_state_nx = S_EMPTY;
                    w_stab_nx  = 4'd0;
                end
            end
            default: begin
                w_state_nx = S_EMPTY;
                w_stab_nx  = 4'd0;
            end
        endcase
    end

    // Counters; clr overrides a coinciding increment, the strobe still fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < int'(NGRP); g++) r_cnt[g] <= '0;
            r_sat       <= '0;
            r_total     <= 16'd0;
            r_cnt_pulse <= 1'b0;
            r_cnt_grp   <= 4'd0;
        end else begin
            r_cnt_pulse <= w_take;
            r_cnt_grp   <= w_take ? w_grp : 4'd0;
            if (clr) begin
                for (int g = 0; g < int'(NGRP); g++) r_cnt[g] <= '0;
                r_sat   <= '0;
                r_total <= 16'd0;
            end else if (w_take) begin
                for (int g = 0; g < int'(NGRP); g++) begin
                    if (w_grp == 4'(g + 1)) begin
                        if (r_cnt[g] == CNT_MAX) r_sat[g] <= 1'b1;
                        else                     r_cnt[g] <= r_cnt[g] + 1'b1;
                    end
                end
                if (r_total != 16'hFFFF) r_total <= r_total + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(NGRP); g++) begin : g_pack
        assign counts[g*CW +: CW] = r_cnt[g];
    end

    assign cur_grp   = w_grp;
    assign sat       = r_sat;
    assign total     = r_total;
    assign cnt_pulse = r_cnt_pulse;
    assign cnt_grp   = r_cnt_grp;

endmodule

// File: tb/tb_weight_bin_counter.sv
// Scoreboard bench: stimulus queues expected cnt_grp values, a negedge monitor
// pops one per cnt_pulse; state checks use hand-computed constants.
module tb_weight_bin_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] weight;
    logic        clr;
    logic        thr_we;
    logic [3:0]  thr_idx;
    logic [11:0] thr_data;
    logic [3:0]  cur_grp;
    logic [47:0] counts;
    logic [5:0]  sat;
    logic        cnt_pulse;
    logic [3:0]  cnt_grp;
    logic [15:0] total;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    weight_bin_counter dut (
        .clk(clk), .reset(reset), .weight(weight), .clr(clr),
        .thr_we(thr_we), .thr_idx(thr_idx), .thr_data(thr_data),
        .cur_grp(cur_grp), .counts(counts), .sat(sat),
        .cnt_pulse(cnt_pulse), .cnt_grp(cnt_grp), .total(total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int grp_cnt(input int g);
        logic [47:0] v;
        v = counts >> ((g - 1) * 8);
        return int'(v[7:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input int w, input int n);
        weight = 12'(w);
        repeat (n) tick();
        weight = 12'd0;
        tick();
    endtask

    task automatic thr_write(input int idx, input int val);
        thr_we = 1'b1; thr_idx = 4'(idx); thr_data = 12'(val);
        tick();
        thr_we = 1'b0;
    endtask

    task automatic grp_of(input string name, input int w, input int exp);
        weight = 12'(w);
        #1;
        chk(name, int'(cur_grp), exp);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (cnt_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'(cnt_grp), -1);
                end else begin
                    chk("cnt_grp", int'(cnt_grp), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; weight = 12'd0; clr = 1'b0;
        thr_we = 1'b0; thr_idx = 4'd0; thr_data = 12'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        chk("rst_counts", int'(counts != 48'd0), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_pulse", int'(cnt_pulse), 0);
        chk("rst_cnt_grp", int'(cnt_grp), 0);
        chk("rst_cur_grp", int'(cur_grp), 0);

        grp_of("cls_1", 1, 1);
        grp_of("cls_250", 250, 1);
        grp_of("cls_251", 251, 2);
        grp_of("cls_1250", 1250, 5);
        grp_of("cls_1251", 1251, 6);
        grp_of("cls_4095", 4095, 6);
        weight = 12'd0;
        tick();

        exp_q.push_back(2);
        place(300, 2);
        chk("basic_grp2", grp_cnt(2), 1);
        chk("basic_total", int'(total), 1);

        // Bounce 300 -> 800 settles on grp4; a one-cycle 300 never counts.
        exp_q.push_back(4);
        weight = 12'd300; tick();
        place(800, 2);
        place(300, 1);
        tick();
        chk("bounce_grp2", grp_cnt(2), 1);
        chk("bounce_grp4", grp_cnt(4), 1);
        chk("bounce_total", int'(total), 2);

        exp_q.push_back(1);
        weight = 12'd100; repeat (5) tick();
        place(3000, 5);
        chk("held_grp1", grp_cnt(1), 1);
        chk("held_grp6", grp_cnt(6), 0);

        thr_write(0, 50);
        grp_of("thr0_100", 100, 2);
        grp_of("thr0_40", 40, 1);
        exp_q.push_back(2);
        place(100, 2);
        chk("thr_grp2", grp_cnt(2), 2);
        chk("thr_total", int'(total), 4);
        thr_write(9, 5);
        grp_of("bad_idx_40", 40, 1);
        grp_of("bad_idx_600", 600, 3);
        weight = 12'd0;
        tick();

        // clr lands on the same edge as the grp3 count.
        weight = 12'd600; tick();
        exp_q.push_back(3);
        clr = 1'b1; tick();
        clr = 1'b0;
        weight = 12'd0; tick();
        chk("clr_grp3", grp_cnt(3), 0);
        chk("clr_counts", int'(counts != 48'd0), 0);
        chk("clr_total", int'(total), 0);

        for (int k = 0; k < 256; k++) begin
            exp_q.push_back(6);
            place(2500, 2);
            if (k == 254) begin
                chk("sat255_grp6", grp_cnt(6), 255);
                chk("sat255_flag", int'(sat), 0);
            end
        end
        chk("sat_grp6", grp_cnt(6), 255);
        chk("sat_flag", int'(sat), 32);
        chk("sat_total", int'(total), 256);

        weight = 12'd300; tick();
        #2 reset = 1'b1;
        weight = 12'd0;
        #1;
        chk("midrst_counts", int'(counts != 48'd0), 0);
        chk("midrst_sat", int'(sat), 0);
        chk("midrst_total", int'(total), 0);
        chk("midrst_pulse", int'(cnt_pulse), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_total", int'(total), 0);
        grp_of("post_rst_thr0", 100, 1);
        weight = 12'd0;
        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_bin_counter.md
WEIGHT_BIN_COUNTER -- requirements
Module: weight_bin_counter

Parameters
REQ-001 SHALL provide parameter W, default 12, weight input width in bits.
REQ-002 SHALL provide parameter NGRP, default 6, number of non-empty groups (2..15).
REQ-003 SHALL provide parameter CW, default 8, per-group count width.
REQ-004 SHALL provide parameter STABLE, default 2, consecutive cycles (1..15) a nonzero weight must hold one group before it is counted.

Interface
REQ-005 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have: reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have: weight  input  W  current scale reading; 0 means scale empty.
REQ-008 SHALL have: clr  input  1  synchronous clear of all counts and saturation flags.
REQ-009 SHALL have: thr_we  input  1  threshold write strobe.
REQ-010 SHALL have: thr_idx  input  4  threshold index, 0..NGRP-2; any other value makes the write ignored.
REQ-011 SHALL have: thr_data  input  W  threshold value to write.
REQ-012 SHALL have: cur_grp  output  4  combinational group of the present weight (0 = empty).
REQ-013 SHALL have: counts  output  NGRP*CW  packed counts; group g occupies bits [g*CW-1:(g-1)*CW].
REQ-014 SHALL have: sat  output  NGRP  per-group saturation flag; bit g-1 belongs to group g.
REQ-015 SHALL have: cnt_pulse  output  1  one-cycle strobe, high in the cycle after a count is taken.
REQ-016 SHALL have: cnt_grp  output  4  group counted, valid while cnt_pulse is high.
REQ-017 SHALL have: total  output  16  total items counted, saturating at 16'hFFFF.

Function
REQ-018 SHALL hold NGRP-1 thresholds thr[0..NGRP-2], each W bits wide.
REQ-019 SHALL classify combinationally: weight==0 -> group 0; otherwise group = 1 + i for the smallest i with weight < thr[i]; NGRP if no such i.
REQ-020 SHALL have the classification resolve overlapping or non-ascending thresholds by the smallest-index rule only, with no error flag.
REQ-021 SHALL, on thr_we with a valid thr_idx, write thr[thr_idx] at the clock edge; the new value governs cur_grp from the following cycle.
REQ-022 SHALL implement FSM states EMPTY, SETTLE and HELD.
REQ-023 EMPTY: cur_grp==0 -> stay; otherwise -> SETTLE, latch cand=cur_grp, stable counter=1.
REQ-024 SETTLE: cur_grp==0 -> EMPTY with no count; cur_grp!=cand -> stay, cand=cur_grp, counter=1; cur_grp==cand -> counter+1.
REQ-025 SETTLE: when the counter reaches STABLE -> HELD and increment count[cand]; with STABLE=1 the count is taken on the EMPTY->SETTLE edge and the FSM goes directly to HELD.
REQ-026 HELD: cur_grp==0 -> EMPTY; otherwise stay, so at most one count per placement regardless of weight changes.
REQ-027 SHALL saturate each count at 2^CW-1 and set the matching sat bit when an increment is attempted at that maximum.
REQ-028 SHALL increment total on every taken count, including counts lost to saturation, saturating at 16'hFFFF.
REQ-029 SHALL assert cnt_pulse for exactly one cycle per count taken, with cnt_grp=cand.
REQ-030 SHALL, on clr, zero counts, sat and total; when clr coincides with an increment, clr wins and that increment is lost.
REQ-031 SHALL not let clr affect the FSM state or the thresholds; cnt_pulse still fires for a count that coincides with clr.

Reset
REQ-032 SHALL, on reset, force state=EMPTY, counts=0, sat=0, total=0, cnt_pulse=0, cnt_grp=0 and stable counter=0, immediately and irrespective of clk.
REQ-033 SHALL, on reset, set thr[i]=(250*(i+1)+1) truncated to W bits, giving 251/501/751/1001/1251 at the defaults.
REQ-034 SHALL discard any in-progress SETTLE placement when reset is asserted mid-operation; no count results from it.

Verification
REQ-035 Defaults: weight 0 -> 300 held 2 cycles -> 0 -> count grp2=1, cnt_pulse once with cnt_grp=2, total=1.
REQ-036 Bounce: weight 300 for 1 cycle, 800 for 2 cycles, 0 -> only grp4 increments; 300 for 1 cycle then 0 -> no count.
REQ-037 Held change: weight 100 held 5 cycles, changed to 3000 for 5 cycles, then 0 -> grp1=1 and grp6=0.
REQ-038 Saturation (CW=8): 256 placements of weight 2500 -> grp6=255, sat[5]=1, total=256.
REQ-039 Threshold write: write thr[0]=50 then weight 100 stable -> grp2 counted; write with thr_idx=9 -> thresholds unchanged.
REQ-040 Collisions: clr in the same cycle as an increment -> that group count=0 and cnt_pulse=1; reset pulse mid-SETTLE -> all outputs 0 and no count taken.
